// File: rtl/iol_deser.sv
// Input capture and deserialiser for I/O-logic pins: SDR or pre-captured DDR
// samples, optional input register, per-channel word assembly with bitslip.
module iol_deser #(
  parameter int WIDTH  = 1,
  parameter int DESER  = 4,
  parameter int DDR    = 0,
  parameter int REG_IN = 1
) (
  input  logic                   CK,
  input  logic                   CD,
  input  logic [WIDTH-1:0]       D0,
  input  logic [WIDTH-1:0]       D1,
  input  logic                   SP,
  input  logic                   SLIP,
  output logic [WIDTH*DESER-1:0] Q,
  output logic                   Q_VALID,
  output logic                   SLIP_RDY
);

  localparam int BPC      = (DDR != 0) ? 2 : 1;
  localparam int WORD_CYC = DESER / BPC;
  localparam int CNT_W    = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_CYC - 1);

  logic [WIDTH-1:0] d0_s;
  logic [WIDTH-1:0] d1_s;
  logic             sp_s;
  logic             slip_s;

  // The input stage is free-running so data, enable and slip stay cycle-aligned.
  if (REG_IN != 0) begin : g_reg_in
    logic [WIDTH-1:0] d0_q;
    logic [WIDTH-1:0] d1_q;
    logic             sp_q;
    logic             slip_q;

    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        d0_q   <= '0;
        d1_q   <= '0;
        sp_q   <= 1'b0;
        slip_q <= 1'b0;
      end else begin
        d0_q   <= D0;
        d1_q   <= D1;
        sp_q   <= SP;
        slip_q <= SLIP;
      end
    end

    assign d0_s   = d0_q;
    assign d1_s   = d1_q;
    assign sp_s   = sp_q;
    assign slip_s = slip_q;
  end else begin : g_no_reg_in
    assign d0_s   = D0;
    assign d1_s   = D1;
    assign sp_s   = SP;
    assign slip_s = SLIP;
  end

  logic [WIDTH-1:0][DESER-1:0] sr_q;
  logic [WIDTH-1:0][DESER-1:0] sr_d;
  logic [WIDTH-1:0][DESER-1:0] sr_shift;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic [WIDTH*DESER-1:0]      q_q;
  logic [WIDTH*DESER-1:0]      q_d;
  logic                        q_valid_q;
  logic                        q_valid_d;
  logic                        slip_rdy_q;
  logic                        slip_rdy_d;
  logic                        slip_acc;

  for (genvar c = 0; c < WIDTH; c++) begin : g_ch
    // The oldest BPC bits fall off the end of each shift and are never read.
    logic [BPC-1:0] unused_top;
    assign unused_top = sr_q[c][DESER-1 -: BPC];

    if (DDR == 0) begin : g_sdr
      assign sr_shift[c] = {sr_q[c][DESER-2:0], d0_s[c]};
    end else if (DESER == 2) begin : g_ddr2
      assign sr_shift[c] = {d0_s[c], d1_s[c]};
    end else begin : g_ddr
      assign sr_shift[c] = {sr_q[c][DESER-3:0], d0_s[c], d1_s[c]};
    end
  end

  if (DDR == 0) begin : g_d1_unused
    logic unused_d1;
    assign unused_d1 = ^d1_s;
  end

  assign slip_acc = sp_s & slip_s & slip_rdy_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    slip_rdy_d = slip_rdy_q;
    if (sp_s) begin
      sr_d = sr_shift;
      // An accepted slip eats one cycle of the word, moving the boundary later by BPC bits.
      if (slip_acc) begin
        slip_rdy_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        q_d        = sr_shift;
        q_valid_d  = 1'b1;
        slip_rdy_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      slip_rdy_q <= 1'b1;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      slip_rdy_q <= slip_rdy_d;
    end
  end

  assign Q        = q_q;
  assign Q_VALID  = q_valid_q;
  assign SLIP_RDY = slip_rdy_q;

endmodule

// File: tb/tb_iol_deser.sv
// Self-checking bench for iol_deser: three configurations, expected words
// queued as stimulus is driven and popped whenever Q_VALID pulses.
module tb_iol_deser;

  logic CK = 1'b0;
  logic CD = 1'b1;

  always #5 CK = ~CK;

  // SDR, 4-bit words, no input stage
  logic [0:0] sdr_d0 = '0, sdr_d1 = '0;
  logic       sdr_sp = 1'b0, sdr_slip = 1'b0;
  logic [3:0] sdr_q;
  logic       sdr_qv, sdr_rdy;

  // DDR, two channels, 4-bit words, input stage
  logic [1:0] ddr_d0 = '0, ddr_d1 = '0;
  logic       ddr_sp = 1'b0, ddr_slip = 1'b0;
  logic [7:0] ddr_q;
  logic       ddr_qv, ddr_rdy;

  // DDR, one channel, 8-bit words, input stage
  logic [0:0] b2b_d0 = '0, b2b_d1 = '0;
  logic       b2b_sp = 1'b0, b2b_slip = 1'b0;
  logic [7:0] b2b_q;
  logic       b2b_qv, b2b_rdy;

  iol_deser #(.WIDTH(1), .DESER(4), .DDR(0), .REG_IN(0)) u_sdr (
    .CK(CK), .CD(CD), .D0(sdr_d0), .D1(sdr_d1), .SP(sdr_sp), .SLIP(sdr_slip),
    .Q(sdr_q), .Q_VALID(sdr_qv), .SLIP_RDY(sdr_rdy)
  );

  iol_deser #(.WIDTH(2), .DESER(4), .DDR(1), .REG_IN(1)) u_ddr (
    .CK(CK), .CD(CD), .D0(ddr_d0), .D1(ddr_d1), .SP(ddr_sp), .SLIP(ddr_slip),
    .Q(ddr_q), .Q_VALID(ddr_qv), .SLIP_RDY(ddr_rdy)
  );

  iol_deser #(.WIDTH(1), .DESER(8), .DDR(1), .REG_IN(1)) u_b2b (
    .CK(CK), .CD(CD), .D0(b2b_d0), .D1(b2b_d1), .SP(b2b_sp), .SLIP(b2b_slip),
    .Q(b2b_q), .Q_VALID(b2b_qv), .SLIP_RDY(b2b_rdy)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] sb_sdr[$];
  logic [7:0] sb_ddr[$];
  logic [7:0] sb_b2b[$];

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic clear_inputs;
    sdr_d0 = '0; sdr_d1 = '0; sdr_sp = 1'b0; sdr_slip = 1'b0;
    ddr_d0 = '0; ddr_d1 = '0; ddr_sp = 1'b0; ddr_slip = 1'b0;
    b2b_d0 = '0; b2b_d1 = '0; b2b_sp = 1'b0; b2b_slip = 1'b0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    CD = 1'b1;
    repeat (2) @(posedge CK);
    @(negedge CK);
    CD = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    CD = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    vectors++; if (sdr_q !== 4'h0) begin miscompares++; $display("FAIL reset sdr_q: got %h want 0", sdr_q); end
    vectors++; if (sdr_qv !== 1'b0) begin miscompares++; $display("FAIL reset sdr_qv: got %b want 0", sdr_qv); end
    vectors++; if (sdr_rdy !== 1'b1) begin miscompares++; $display("FAIL reset sdr_rdy: got %b want 1", sdr_rdy); end
    vectors++; if (ddr_q !== 8'h00) begin miscompares++; $display("FAIL reset ddr_q: got %h want 00", ddr_q); end
    vectors++; if (ddr_qv !== 1'b0) begin miscompares++; $display("FAIL reset ddr_qv: got %b want 0", ddr_qv); end
    vectors++; if (ddr_rdy !== 1'b1) begin miscompares++; $display("FAIL reset ddr_rdy: got %b want 1", ddr_rdy); end
    vectors++; if (b2b_q !== 8'h00) begin miscompares++; $display("FAIL reset b2b_q: got %h want 00", b2b_q); end
    vectors++; if (b2b_qv !== 1'b0) begin miscompares++; $display("FAIL reset b2b_qv: got %b want 0", b2b_qv); end
    vectors++; if (b2b_rdy !== 1'b1) begin miscompares++; $display("FAIL reset b2b_rdy: got %b want 1", b2b_rdy); end
    @(negedge CK);
    CD = 1'b0;
  endtask

  // Runs one SDR cycle and checks Q_VALID against want_v, popping the scoreboard on a word.
  task automatic sdr_step(input logic d, input logic sp, input logic slip,
                          input logic want_v, input string tag);
    logic [3:0] exp;
    sdr_d0 = d; sdr_sp = sp; sdr_slip = slip;
    tick();
    vectors++;
    if (sdr_qv !== want_v) begin
      miscompares++; $display("FAIL %s sdr_qv: got %b want %b", tag, sdr_qv, want_v);
    end
    if (sdr_qv === 1'b1) begin
      vectors++;
      if (sb_sdr.size() == 0) begin
        miscompares++; $display("FAIL %s sdr word: got %h want none", tag, sdr_q);
      end else begin
        exp = sb_sdr.pop_front();
        if (sdr_q !== exp) begin
          miscompares++; $display("FAIL %s sdr_q: got %b want %b", tag, sdr_q, exp);
        end
      end
    end
  endtask

  task automatic test_sdr_basic;
    logic [3:0] bits;
    apply_reset();
    bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_sdr.push_back(4'b1011);
      sdr_step(bits[3-i], 1'b1, 1'b0, i == 3, "sdr_basic");
    end
    sdr_step(1'b0, 1'b0, 1'b0, 1'b0, "sdr_basic_after");
    vectors++;
    if (sdr_q !== 4'b1011) begin
      miscompares++; $display("FAIL sdr_basic_hold sdr_q: got %b want 1011", sdr_q);
    end
  endtask

  task automatic test_clock_enable;
    int d_pat[6]  = '{1, 0, 0, 1, 1, 0};
    int sp_pat[6] = '{1, 0, 1, 1, 1, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) sb_sdr.push_back(4'b1011);
      sdr_step(1'(d_pat[i]), 1'(sp_pat[i]), 1'b0, i == 4, "clock_enable");
    end
  endtask

  task automatic test_bitslip;
    logic want_rdy;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 7)   sb_sdr.push_back(4'b1000);
      if (i == 12 || i == 16) sb_sdr.push_back(4'b0001);
      sdr_step((i % 4) == 0, 1'b1, (i == 9) || (i == 10),
               (i == 3) || (i == 7) || (i == 12) || (i == 16), "bitslip");
      want_rdy = !((i >= 9) && (i <= 11));
      vectors++;
      if (sdr_rdy !== want_rdy) begin
        miscompares++; $display("FAIL bitslip cycle %0d sdr_rdy: got %b want %b", i, sdr_rdy, want_rdy);
      end
    end
    sdr_slip = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [3:0] w1, w2;
    apply_reset();
    w1 = 4'b0110;
    w2 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_sdr.push_back(w1);
      sdr_step(w1[3-i], 1'b1, 1'b0, i == 3, "areset_pre");
    end
    sdr_step(1'b1, 1'b1, 1'b1, 1'b0, "areset_slip");
    vectors++;
    if (sdr_rdy !== 1'b0) begin
      miscompares++; $display("FAIL areset_slip sdr_rdy: got %b want 0", sdr_rdy);
    end
    sdr_step(1'b1, 1'b1, 1'b0, 1'b0, "areset_partial");
    #2;
    CD = 1'b1;
    #1;
    vectors++; if (sdr_q !== 4'h0) begin miscompares++; $display("FAIL areset_async sdr_q: got %b want 0000", sdr_q); end
    vectors++; if (sdr_qv !== 1'b0) begin miscompares++; $display("FAIL areset_async sdr_qv: got %b want 0", sdr_qv); end
    vectors++; if (sdr_rdy !== 1'b1) begin miscompares++; $display("FAIL areset_async sdr_rdy: got %b want 1", sdr_rdy); end
    @(negedge CK);
    CD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_sdr.push_back(w2);
      sdr_step(w2[3-i], 1'b1, 1'b0, i == 3, "areset_post");
    end
  endtask

  task automatic test_ddr;
    logic [1:0] d0_pat[4] = '{2'b01, 2'b10, 2'b00, 2'b00};
    logic [1:0] d1_pat[4] = '{2'b11, 2'b00, 2'b00, 2'b00};
    logic       sp_pat[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ddr_d0 = d0_pat[i]; ddr_d1 = d1_pat[i]; ddr_sp = sp_pat[i];
      if (i == 1) sb_ddr.push_back(8'b0110_1100);
      tick();
      vectors++;
      if (ddr_qv !== (i == 2)) begin
        miscompares++; $display("FAIL ddr edge %0d ddr_qv: got %b want %b", i + 1, ddr_qv, i == 2);
      end
      if (ddr_qv === 1'b1) begin
        vectors++;
        if (sb_ddr.size() == 0) begin
          miscompares++; $display("FAIL ddr word: got %h want none", ddr_q);
        end else begin
          exp = sb_ddr.pop_front();
          if (ddr_q !== exp) begin
            miscompares++; $display("FAIL ddr ddr_q: got %b want %b", ddr_q, exp);
          end
        end
      end
    end
    vectors++;
    if (ddr_q !== 8'b0110_1100) begin
      miscompares++; $display("FAIL ddr_hold ddr_q: got %b want 01101100", ddr_q);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[3] = '{8'hA5, 8'h3C, 8'h96};
    logic [7:0] cur;
    logic [7:0] exp;
    logic       want_v;
    int         k;
    apply_reset();
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc < 12) begin
        cur = bytes[cyc / 4];
        k   = cyc % 4;
        b2b_d0 = cur[7 - 2*k];
        b2b_d1 = cur[6 - 2*k];
        b2b_sp = 1'b1;
        if (k == 3) sb_b2b.push_back(cur);
      end else begin
        b2b_d0 = '0; b2b_d1 = '0; b2b_sp = 1'b0;
      end
      tick();
      want_v = (cyc == 4) || (cyc == 8) || (cyc == 12);
      vectors++;
      if (b2b_qv !== want_v) begin
        miscompares++; $display("FAIL b2b edge %0d b2b_qv: got %b want %b", cyc + 1, b2b_qv, want_v);
      end
      if (b2b_qv === 1'b1) begin
        vectors++;
        if (sb_b2b.size() == 0) begin
          miscompares++; $display("FAIL b2b word: got %h want none", b2b_q);
        end else begin
          exp = sb_b2b.pop_front();
          if (b2b_q !== exp) begin
            miscompares++; $display("FAIL b2b b2b_q: got %h want %h", b2b_q, exp);
          end
        end
      end
    end
  endtask

  task automatic test_drain;
    vectors++; if (sb_sdr.size() != 0) begin miscompares++; $display("FAIL drain sdr: got %0d left want 0", sb_sdr.size()); end
    vectors++; if (sb_ddr.size() != 0) begin miscompares++; $display("FAIL drain ddr: got %0d left want 0", sb_ddr.size()); end
    vectors++; if (sb_b2b.size() != 0) begin miscompares++; $display("FAIL drain b2b: got %0d left want 0", sb_b2b.size()); end
  endtask

  initial begin
    test_reset();
    test_sdr_basic();
    test_clock_enable();
    test_bitslip();
    test_async_reset();
    test_ddr();
    test_back_to_back();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
